// File: rtl/router_pkt_fifo.sv
// rtl/router_pkt_fifo.sv - packet-aware router FIFO with level, packet count and sop/eop strobes
// Header words carry {payload_len, addr}; the read side counts payload plus parity to place eop.
module router_pkt_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AW        = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              soft_reset,
  input  logic              write_enb,
  input  logic              read_enb,
  input  logic              lfd_state,
  input  logic [DATA_W-1:0] data_in,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [AW:0]       level,
  output logic [AW:0]       pkt_count,
  output logic              overflow,
  output logic [DATA_W-1:0] data_out,
  output logic              sop_out,
  output logic              eop_out
);

  localparam int RW = DATA_W - 1;

  logic [DATA_W:0]   mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [RW-1:0]     rem;
  logic [DATA_W:0]   rd_word;
  logic              rd_acc;
  logic              wr_acc;
  logic              wr_hdr;
  logic              rd_hdr;

  // Status flags come straight off the level register, never from the request inputs.
  assign full        = (level == (AW+1)'(DEPTH));
  assign empty       = (level == '0);
  assign almost_full = (level >= (AW+1)'(AF_THRESH));

  assign rd_word = mem[rd_ptr];
  assign rd_acc  = read_enb && !empty;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign wr_acc  = write_enb && (!full || rd_acc);
  assign wr_hdr  = wr_acc && lfd_state;
  assign rd_hdr  = rd_acc && rd_word[DATA_W];

  always_ff @(posedge clock) begin
    if (resetn && !soft_reset && wr_acc) begin
      mem[wr_ptr] <= {lfd_state, data_in};
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
      rem       <= '0;
      overflow  <= 1'b0;
      data_out  <= '0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
    end else if (soft_reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      pkt_count <= '0;
      rem       <= '0;
      overflow  <= 1'b0;
      data_out  <= '0;
      sop_out   <= 1'b0;
      eop_out   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (write_enb && !wr_acc) begin
        overflow <= 1'b1;
      end

      case ({wr_acc, rd_acc})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase

      pkt_count <= pkt_count + (AW+1)'(wr_hdr) - (AW+1)'(rd_hdr);

      if (rd_acc) begin
        rd_ptr   <= rd_ptr + AW'(1);
        data_out <= rd_word[DATA_W-1:0];
        if (rd_word[DATA_W]) begin
          // Payload words plus the trailing parity word.
          rem     <= {1'b0, rd_word[DATA_W-1:2]} + RW'(1);
          sop_out <= 1'b1;
          eop_out <= 1'b0;
        end else begin
          sop_out <= 1'b0;
          if (rem != '0) begin
            rem     <= rem - RW'(1);
            eop_out <= (rem == RW'(1));
          end else begin
            eop_out <= 1'b0;
          end
        end
      end else if (read_enb) begin
        sop_out <= 1'b0;
        eop_out <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// tb/tb_router_pkt_fifo.sv - self-checking bench for router_pkt_fifo
// Vector table, directed packet sequences and random traffic against a queue-based model.
module tb_router_pkt_fifo;

  localparam int DW = 8;
  localparam int DP = 16;
  localparam int AF = 14;
  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          resetn = 1'b1;
  logic          soft_reset = 1'b0;
  logic          write_enb = 1'b0;
  logic          read_enb = 1'b0;
  logic          lfd_state = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          full, empty, almost_full, overflow, sop_out, eop_out;
  logic [AW:0]   level, pkt_count;
  logic [DW-1:0] data_out;

  router_pkt_fifo #(.DATA_W(DW), .DEPTH(DP), .AF_THRESH(AF)) dut (
    .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
    .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
    .data_in(data_in), .full(full), .empty(empty), .almost_full(almost_full),
    .level(level), .pkt_count(pkt_count), .overflow(overflow),
    .data_out(data_out), .sop_out(sop_out), .eop_out(eop_out)
  );

  always #5 clock = ~clock;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference: the FIFO as a queue of {is_header, word}; rem = words left in the packet being read.
  logic [DW:0]   mq[$];
  int            m_rem;
  logic [DW-1:0] m_data;
  bit            m_sop, m_eop, m_ovf;

  function automatic void m_reset();
    mq.delete();
    m_rem = 0; m_data = '0; m_sop = 0; m_eop = 0; m_ovf = 0;
  endfunction

  function automatic int m_hdrs();
    int n = 0;
    foreach (mq[i]) if (mq[i][DW]) n++;
    return n;
  endfunction

  function automatic void model_step(bit sr, bit we, bit re, bit lfd, logic [DW-1:0] din);
    bit rd_ok, wr_ok;
    logic [DW:0] w;
    if (sr) begin
      m_reset();
      return;
    end
    rd_ok = re && (mq.size() > 0);
    wr_ok = we && (mq.size() < DP || rd_ok);
    if (rd_ok) begin
      w = mq.pop_front();
      m_data = w[DW-1:0];
      m_sop = w[DW];
      if (w[DW]) begin
        m_rem = int'(w[DW-1:2]) + 1;
        m_eop = 0;
      end else if (m_rem > 0) begin
        m_eop = (m_rem == 1);
        m_rem = m_rem - 1;
      end else begin
        m_eop = 0;
      end
    end else if (re) begin
      m_sop = 0;
      m_eop = 0;
    end
    if (we && !wr_ok) m_ovf = 1;
    if (wr_ok) mq.push_back({lfd, din});
  endfunction

  task automatic drive_cycle(input bit sr, input bit we, input bit re, input bit lfd,
                             input logic [DW-1:0] din);
    @(negedge clock);
    soft_reset = sr; write_enb = we; read_enb = re; lfd_state = lfd; data_in = din;
    @(posedge clock);
    model_step(sr, we, re, lfd, din);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, " level"}, level, mq.size());
    chk({tag, " full"}, full, mq.size() == DP);
    chk({tag, " empty"}, empty, mq.size() == 0);
    chk({tag, " almost_full"}, almost_full, mq.size() >= AF);
    chk({tag, " pkt_count"}, pkt_count, m_hdrs());
    chk({tag, " overflow"}, overflow, m_ovf);
    chk({tag, " data_out"}, data_out, m_data);
    chk({tag, " sop"}, sop_out, m_sop);
    chk({tag, " eop"}, eop_out, m_eop);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " empty"}, empty, 1);
    chk({tag, " full"}, full, 0);
    chk({tag, " almost_full"}, almost_full, 0);
    chk({tag, " level"}, level, 0);
    chk({tag, " pkt_count"}, pkt_count, 0);
    chk({tag, " overflow"}, overflow, 0);
    chk({tag, " data_out"}, data_out, 0);
    chk({tag, " sop"}, sop_out, 0);
    chk({tag, " eop"}, eop_out, 0);
  endtask

  typedef struct {
    bit sr, we, re, lfd;
    logic [DW-1:0] din;
    int lvl, pc;
    bit emp;
    logic [DW-1:0] dout;
    bit sop, eop;
  } vec_t;

  vec_t tbl[13];
  logic [DW-1:0] pkt_words[16];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Five writes, soft reset (wins over a write), then a len-1 packet read out.
    tbl[0]  = '{0,1,0,0,8'h11, 1,0,0,8'h00,0,0};
    tbl[1]  = '{0,1,0,0,8'h22, 2,0,0,8'h00,0,0};
    tbl[2]  = '{0,1,0,0,8'h33, 3,0,0,8'h00,0,0};
    tbl[3]  = '{0,1,0,0,8'h44, 4,0,0,8'h00,0,0};
    tbl[4]  = '{0,1,0,0,8'h55, 5,0,0,8'h00,0,0};
    tbl[5]  = '{1,1,0,0,8'h66, 0,0,1,8'h00,0,0};
    tbl[6]  = '{0,1,0,1,8'h05, 1,1,0,8'h00,0,0};
    tbl[7]  = '{0,1,0,0,8'hA1, 2,1,0,8'h00,0,0};
    tbl[8]  = '{0,1,0,0,8'h5C, 3,1,0,8'h00,0,0};
    tbl[9]  = '{0,0,1,0,8'h00, 2,0,0,8'h05,1,0};
    tbl[10] = '{0,0,1,0,8'h00, 1,0,0,8'hA1,0,0};
    tbl[11] = '{0,0,1,0,8'h00, 0,0,1,8'h5C,0,1};
    tbl[12] = '{0,0,1,0,8'h00, 0,0,1,8'h5C,0,0};

    m_reset();
    #2 resetn = 1'b0;
    #1 chk_reset_vals("reset");
    @(negedge clock);
    resetn = 1'b1;

    for (int i = 0; i < 13; i++) begin
      drive_cycle(tbl[i].sr, tbl[i].we, tbl[i].re, tbl[i].lfd, tbl[i].din);
      chk($sformatf("vec%0d level", i), level, tbl[i].lvl);
      chk($sformatf("vec%0d pkt_count", i), pkt_count, tbl[i].pc);
      chk($sformatf("vec%0d empty", i), empty, tbl[i].emp);
      chk($sformatf("vec%0d data_out", i), data_out, tbl[i].dout);
      chk($sformatf("vec%0d sop", i), sop_out, tbl[i].sop);
      chk($sformatf("vec%0d eop", i), eop_out, tbl[i].eop);
      chk($sformatf("vec%0d overflow", i), overflow, 0);
    end

    // Header 0x39 (len 14), 14 payload words, parity: fills the FIFO exactly.
    pkt_words[0] = 8'h39;
    for (int k = 1; k < 16; k++) pkt_words[k] = 8'($urandom);
    for (int k = 0; k < 16; k++) begin
      drive_cycle(0, 1, 0, k == 0, pkt_words[k]);
      check_model($sformatf("fill%0d", k + 1));
      chk($sformatf("fill%0d af", k + 1), almost_full, (k + 1) >= AF);
    end
    chk("pkt full", full, 1);
    chk("pkt level", level, 16);
    chk("pkt count", pkt_count, 1);
    drive_cycle(0, 1, 0, 0, 8'hEE);
    chk("drop overflow", overflow, 1);
    chk("drop level", level, 16);

    for (int k = 0; k < 16; k++) begin
      drive_cycle(0, 0, 1, 0, 8'h00);
      check_model($sformatf("drain%0d", k + 1));
      chk($sformatf("drain%0d data", k + 1), data_out, pkt_words[k]);
      chk($sformatf("drain%0d sop", k + 1), sop_out, k == 0);
      chk($sformatf("drain%0d eop", k + 1), eop_out, k == 15);
    end
    chk("drained empty", empty, 1);
    chk("drained pkt_count", pkt_count, 0);
    drive_cycle(0, 0, 1, 0, 8'h00);
    chk("extra read data", data_out, pkt_words[15]);
    chk("extra read eop", eop_out, 0);

    // Full FIFO with simultaneous read and write for 8 cycles.
    drive_cycle(1, 0, 0, 0, 8'h00);
    chk("sr overflow", overflow, 0);
    for (int k = 0; k < 16; k++) drive_cycle(0, 1, 0, ($urandom % 4) == 0, 8'($urandom));
    for (int k = 0; k < 8; k++) begin
      drive_cycle(0, 1, 1, ($urandom % 4) == 0, 8'($urandom));
      check_model($sformatf("rw_full%0d", k));
      chk($sformatf("rw_full%0d full", k), full, 1);
      chk($sformatf("rw_full%0d overflow", k), overflow, 0);
    end

    // Random traffic across pointer wrap, biased toward filling and then draining.
    for (int k = 0; k < 400; k++) begin
      int wp;
      wp = (k % 100 < 50) ? 70 : 35;
      drive_cycle(($urandom % 97) == 0, ($urandom % 100) < wp, ($urandom % 100) < 55,
                  ($urandom % 4) == 0, 8'($urandom));
      check_model($sformatf("rnd%0d", k));
    end

    // Asynchronous reset between edges, with data still queued.
    for (int k = 0; k < 6; k++) drive_cycle(0, 1, k > 2, k == 0, 8'($urandom));
    drive_cycle(0, 0, 0, 0, 8'h00);
    @(posedge clock);
    #3 resetn = 1'b0;
    m_reset();
    #1 chk_reset_vals("async reset");
    @(negedge clock);
    resetn = 1'b1;
    drive_cycle(0, 1, 0, 1, 8'h05);
    drive_cycle(0, 0, 1, 0, 8'h00);
    check_model("post reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
